// File: rtl/irq_controller.sv
// irq_controller: edge-triggered, maskable, fixed-priority interrupt controller with a byte-wide register port.
// Ports:
//    CLK, RESETN      system clock, asynchronous active-low reset
//    SRC_IRQ/SRC_ACK  per-source level request in, one-cycle acknowledge pulse out
//    BUS_*            8-bit register port: BASE+0 MASK (RW), BASE+1 PENDING (R, W1C), BASE+2 STATUS (R)
//    CPU_*            request and id presented to the CPU, single-cycle acknowledge back
module irq_controller #(
   parameter int          N_SRC     = 4,
   parameter logic [7:0]  BASE_ADDR = 8'hF0
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic [N_SRC-1:0] SRC_IRQ,
   output logic [N_SRC-1:0] SRC_ACK,
   inout  wire  [7:0]       BUS_DATA,
   input  logic [7:0]       BUS_ADDR,
   input  logic             BUS_WE,
   output logic             CPU_IRQ,
   output logic [2:0]       CPU_IRQ_ID,
   input  logic             CPU_ACK
);
   typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;
   // Mask and pending are held byte-wide so unused bits stay zero and read back as 0.
   localparam logic [7:0] VALID = 8'((9'd1 << N_SRC) - 9'd1);
   state_t           state_q;
   logic [N_SRC-1:0] src_q, ack_q, rise, active;
   logic [7:0]       mask_q, mask_d, pend_q, pend_d, clr, rd_data_q, rd_data_d;
   logic [2:0]       id_q, low_id;
   logic             irq_q, rd_en_q, sel_mask, sel_pend, sel_stat;
   always_comb begin
      sel_mask  = BUS_ADDR == BASE_ADDR;
      sel_pend  = BUS_ADDR == BASE_ADDR + 8'd1;
      sel_stat  = BUS_ADDR == BASE_ADDR + 8'd2;
      rise      = SRC_IRQ & ~src_q;
      clr       = (BUS_WE && sel_pend ? BUS_DATA : 8'h00) | (state_q == ACK ? 8'(ack_q) : 8'h00);
      // A rising edge wins over any clear landing in the same cycle.
      pend_d    = 8'(rise) | (pend_q & ~clr);
      mask_d    = BUS_WE && sel_mask ? BUS_DATA & VALID : mask_q;
      active    = pend_q[N_SRC-1:0] & mask_q[N_SRC-1:0];
      low_id    = 3'd0;
      for (int i = N_SRC - 1; i >= 0; i--) if (active[i]) low_id = 3'(i);
      rd_data_d = sel_mask ? mask_q : sel_pend ? pend_q : {irq_q, 4'b0000, id_q};
   end
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q   <= IDLE;
         src_q     <= '0;
         pend_q    <= 8'h00;
         mask_q    <= VALID;
         ack_q     <= '0;
         irq_q     <= 1'b0;
         id_q      <= 3'd0;
         rd_en_q   <= 1'b0;
         rd_data_q <= 8'h00;
      end else begin
         src_q     <= SRC_IRQ;
         pend_q    <= pend_d;
         mask_q    <= mask_d;
         rd_en_q   <= !BUS_WE && (sel_mask || sel_pend || sel_stat);
         rd_data_q <= rd_data_d;
         case (state_q)
            IDLE: if (|active) begin
               state_q <= REQ;
               irq_q   <= 1'b1;
               id_q    <= low_id;
            end
            // Once presented, the request is held until the CPU acknowledges it.
            REQ: if (CPU_ACK) begin
               state_q <= ACK;
               irq_q   <= 1'b0;
               ack_q   <= N_SRC'(1) << id_q;
            end
            default: begin
               state_q <= IDLE;
               ack_q   <= '0;
            end
         endcase
      end
   end
   assign SRC_ACK    = ack_q;
   assign CPU_IRQ    = irq_q;
   assign CPU_IRQ_ID = id_q;
   assign BUS_DATA   = rd_en_q ? rd_data_q : 8'bz;
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed stimulus against irq_controller with a cycle-level reference model and literal checkpoints.
module tb_irq_controller;
   localparam int         N = 4;
   localparam logic [7:0] B = 8'hF0;
   logic       clk = 1'b0, resetn = 1'b0, bus_we = 1'b0, cpu_ack = 1'b0, drv = 1'b0;
   logic [3:0] src_irq = 4'h0;
   logic [7:0] bus_addr = 8'h00, drv_data = 8'h00, d;
   wire  [3:0] src_ack;
   wire  [7:0] bus;
   wire        cpu_irq;
   wire  [2:0] cpu_id;
   int         checks = 0, fails = 0;
   assign bus = drv ? drv_data : 8'bz;
   always #10 clk = ~clk;
   irq_controller #(.N_SRC(N), .BASE_ADDR(B)) dut (
      .CLK(clk), .RESETN(resetn), .SRC_IRQ(src_irq), .SRC_ACK(src_ack), .BUS_DATA(bus),
      .BUS_ADDR(bus_addr), .BUS_WE(bus_we), .CPU_IRQ(cpu_irq), .CPU_IRQ_ID(cpu_id), .CPU_ACK(cpu_ack)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // Reference model: pending set/clear rules, lowest-index arbitration, and a
   // present -> acknowledge -> one free cycle rhythm, all from the inputs alone.
   bit [3:0] m_src, m_pend, m_mask, m_ack;
   bit       m_irq, m_rd_en;
   int       m_id;
   bit [7:0] m_rd;
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_src <= 0; m_pend <= 0; m_mask <= 4'hF; m_ack <= 0;
         m_irq <= 0; m_id <= 0; m_rd_en <= 0; m_rd <= 0;
      end else begin : mdl
         bit [3:0] np;
         int       pick;
         np = m_pend;
         for (int i = 0; i < N; i++) begin
            if (bus_we && bus_addr == B + 8'd1 && bus[i]) np[i] = 1'b0;
            if (m_ack[i]) np[i] = 1'b0;
            if (src_irq[i] && !m_src[i]) np[i] = 1'b1;
         end
         m_pend <= np;
         m_src  <= src_irq;
         if (bus_we && bus_addr == B) m_mask <= bus[3:0];
         m_rd_en <= !bus_we && (bus_addr == B || bus_addr == B + 8'd1 || bus_addr == B + 8'd2);
         m_rd    <= bus_addr == B ? {4'h0, m_mask} : bus_addr == B + 8'd1 ? {4'h0, m_pend} : {m_irq, 4'h0, 3'(m_id)};
         pick = -1;
         for (int i = N - 1; i >= 0; i--) if (m_pend[i] && m_mask[i]) pick = i;
         if (m_ack != 0) m_ack <= 0;
         else if (m_irq) begin
            if (cpu_ack) begin
               m_irq <= 0;
               m_ack <= 4'(1 << m_id);
            end
         end else if (pick >= 0) begin
            m_irq <= 1;
            m_id  <= pick;
         end
      end
   end
   always @(negedge clk) begin
      chk("cpu_irq", cpu_irq, m_irq);
      chk("src_ack", src_ack, m_ack);
      if (m_irq) chk("cpu_irq_id", cpu_id, m_id);
      if (resetn && m_rd_en && !drv) chk("bus_read", bus, m_rd);
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic wr(input logic [7:0] a, input logic [7:0] v);
      bus_we = 1; bus_addr = a; drv = 1; drv_data = v;
      tick();
      bus_we = 0; bus_addr = 8'h00; drv = 0;
   endtask
   task automatic rd(input logic [7:0] a, output logic [7:0] v);
      bus_addr = a;
      tick();
      v = bus;
      bus_addr = 8'h00;
   endtask
   task automatic ack_pulse();
      cpu_ack = 1;
      tick();
      cpu_ack = 0;
   endtask
   initial begin
      src_irq = 4'hF; drv = 1; drv_data = 8'hA5;
      repeat (3) tick();
      chk("rst_cpu_irq", cpu_irq, 0);
      chk("rst_src_ack", src_ack, 0);
      chk("rst_bus_released", bus, 8'hA5);
      drv = 0; src_irq = 4'h0;
      tick();
      resetn = 1;
      tick();
      rd(B, d);
      chk("rst_mask_read", d, 8'h0F);
      src_irq = 4'b0100;
      tick(); tick();
      chk("single_irq", cpu_irq, 1);
      chk("single_id", cpu_id, 2);
      ack_pulse();
      chk("single_ack", src_ack, 4'b0100);
      chk("single_irq_drop", cpu_irq, 0);
      src_irq = 4'h0;
      tick();
      chk("single_ack_end", src_ack, 0);
      rd(B + 8'd1, d);
      chk("single_pending", d, 8'h00);
      src_irq = 4'b1010;
      tick(); tick();
      chk("prio_first_id", cpu_id, 1);
      ack_pulse();
      chk("prio_first_ack", src_ack, 4'b0010);
      src_irq = 4'b1000;
      tick();
      chk("prio_gap", cpu_irq, 0);
      tick();
      chk("prio_second_irq", cpu_irq, 1);
      chk("prio_second_id", cpu_id, 3);
      ack_pulse();
      chk("prio_second_ack", src_ack, 4'b1000);
      src_irq = 4'h0;
      tick();
      wr(B, 8'h0E);
      src_irq = 4'b0001;
      repeat (3) tick();
      chk("mask_blocked", cpu_irq, 0);
      rd(B + 8'd1, d);
      chk("mask_pending", d, 8'h01);
      rd(B + 8'd2, d);
      chk("mask_status", d, 8'h03);
      wr(B, 8'h0F);
      tick();
      chk("unmask_irq", cpu_irq, 1);
      chk("unmask_id", cpu_id, 0);
      rd(B + 8'd2, d);
      chk("status_req", d, 8'h80);
      ack_pulse();
      chk("unmask_ack", src_ack, 4'b0001);
      src_irq = 4'h0;
      tick();
      wr(B, 8'h0D);
      src_irq = 4'b0010;
      tick(); tick();
      src_irq = 4'h0;
      tick();
      src_irq = 4'b0010;
      wr(B + 8'd1, 8'h02);
      rd(B + 8'd1, d);
      chk("w1c_collision", d, 8'h02);
      src_irq = 4'h0;
      wr(B + 8'd1, 8'h02);
      rd(B + 8'd1, d);
      chk("w1c_clear", d, 8'h00);
      wr(B, 8'h0F);
      src_irq = 4'b1000;
      tick(); tick();
      chk("hold_irq", cpu_irq, 1);
      ack_pulse();
      chk("hold_ack", src_ack, 4'b1000);
      repeat (4) tick();
      chk("hold_no_repend", cpu_irq, 0);
      src_irq = 4'h0;
      tick();
      ack_pulse();
      chk("stray_cpu_ack", src_ack, 0);
      tick();
      src_irq = 4'b0001;
      tick(); tick();
      chk("midreq_irq", cpu_irq, 1);
      resetn = 0;
      #1;
      chk("midreq_reset_irq", cpu_irq, 0);
      src_irq = 4'h0;
      ack_pulse();
      chk("midreq_no_ack", src_ack, 0);
      tick();
      resetn = 1;
      tick();
      rd(B + 8'd1, d);
      chk("midreq_pending", d, 8'h00);
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
